// File: rtl/arb_pkg.sv
// Shared types for the pixel SRAM port arbiter: FSM states and requester indices.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWNED   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam int REQ_BURST_WR  = 0;
    localparam int REQ_SINGLE_WR = 1;
    localparam int REQ_TX_RD     = 2;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester at or after last_owner+1 (mod N_REQ).
module rr_pick #(
    parameter int N_REQ = 3,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_owner,
    output logic [IDX_W-1:0] winner,
    output logic             found
);

    localparam logic [IDX_W:0] N_S = (IDX_W+1)'(N_REQ);

    logic [IDX_W:0] cand;

    // One extra bit lets last_owner+k wrap with a single conditional subtract.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = {1'b0, last_owner} + (IDX_W+1)'(k);
            if (cand >= N_S) begin
                cand = cand - N_S;
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares the RGB pixel SRAM port between sequencers: round-robin grant with lock,
// idle-lock timeout, and tagged read returns routed back to the issuing requester.
module sram_port_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ        = 3,
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int RD_LAT       = 1,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          we,
    input  logic [N_REQ-1:0]          lock,
    input  logic [N_REQ*ADDR_W-1:0]   addr,
    input  logic [N_REQ*DATA_W-1:0]   wdata_r,
    input  logic [N_REQ*DATA_W-1:0]   wdata_g,
    input  logic [N_REQ*DATA_W-1:0]   wdata_b,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          rvalid,
    output logic [DATA_W-1:0]         rdata_r,
    output logic [DATA_W-1:0]         rdata_g,
    output logic [DATA_W-1:0]         rdata_b,
    output logic                      sram_wr_en,
    output logic                      sram_rd_en,
    output logic [ADDR_W-1:0]         sram_addr,
    output logic [DATA_W-1:0]         sram_wdata_r,
    output logic [DATA_W-1:0]         sram_wdata_g,
    output logic [DATA_W-1:0]         sram_wdata_b,
    input  logic [DATA_W-1:0]         sram_rdata_r,
    input  logic [DATA_W-1:0]         sram_rdata_g,
    input  logic [DATA_W-1:0]         sram_rdata_b,
    output logic                      arb_busy,
    output logic                      lock_timeout
);

    localparam int               IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int               CNT_W    = $clog2(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    logic [N_REQ-1:0][ADDR_W-1:0] addr_a;
    logic [N_REQ-1:0][DATA_W-1:0] wdata_r_a, wdata_g_a, wdata_b_a;

    assign addr_a    = addr;
    assign wdata_r_a = wdata_r;
    assign wdata_g_a = wdata_g;
    assign wdata_b_a = wdata_b;

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  last_owner_q, last_owner_d;
    logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              lock_to_q, lock_to_d;
    logic              acc_wr, acc_rd;

    logic [RD_LAT-1:0]             vld_pipe_q, vld_pipe_d;
    logic [RD_LAT-1:0][IDX_W-1:0]  tag_pipe_q, tag_pipe_d;

    logic [IDX_W-1:0] winner;
    logic             found;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req        (req),
        .last_owner (last_owner_q),
        .winner     (winner),
        .found      (found)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        idle_cnt_d   = idle_cnt_q;
        gnt_d        = gnt_q;
        lock_to_d    = 1'b0;
        acc_wr       = 1'b0;
        acc_rd       = 1'b0;
        sram_addr    = '0;
        sram_wdata_r = '0;
        sram_wdata_g = '0;
        sram_wdata_b = '0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d        = OWNED;
                    owner_d        = winner;
                    gnt_d          = '0;
                    gnt_d[winner]  = 1'b1;
                    idle_cnt_d     = '0;
                end
            end

            OWNED: begin
                if (req[owner_q]) begin
                    acc_wr       = we[owner_q];
                    acc_rd       = ~we[owner_q];
                    sram_addr    = addr_a[owner_q];
                    sram_wdata_r = wdata_r_a[owner_q];
                    sram_wdata_g = wdata_g_a[owner_q];
                    sram_wdata_b = wdata_b_a[owner_q];
                end
                // Dropping lock with a final access still performs it, then releases.
                if (!lock[owner_q]) begin
                    state_d = RELEASE;
                    gnt_d   = '0;
                end else if (req[owner_q]) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == CNT_LAST) begin
                    state_d   = RELEASE;
                    gnt_d     = '0;
                    lock_to_d = 1'b1;
                end else if (idle_cnt_q != '1) begin
                    idle_cnt_d = idle_cnt_q + CNT_W'(1);
                end
            end

            RELEASE: begin
                last_owner_d = owner_q;
                state_d      = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // Read tag pipeline keeps shifting regardless of who owns the port now.
    always_comb begin
        vld_pipe_d    = '0;
        tag_pipe_d    = '0;
        vld_pipe_d[0] = acc_rd;
        tag_pipe_d[0] = owner_q;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            tag_pipe_d[i] = tag_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(N_REQ - 1);
            idle_cnt_q   <= '0;
            gnt_q        <= '0;
            lock_to_q    <= 1'b0;
            vld_pipe_q   <= '0;
            tag_pipe_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            idle_cnt_q   <= idle_cnt_d;
            gnt_q        <= gnt_d;
            lock_to_q    <= lock_to_d;
            vld_pipe_q   <= vld_pipe_d;
            tag_pipe_q   <= tag_pipe_d;
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_rv
        assign rvalid[g] = vld_pipe_q[RD_LAT-1] && (tag_pipe_q[RD_LAT-1] == IDX_W'(g));
    end

    assign gnt          = gnt_q;
    assign sram_wr_en   = acc_wr;
    assign sram_rd_en   = acc_rd;
    assign arb_busy     = (state_q != IDLE);
    assign lock_timeout = lock_to_q;
    assign rdata_r      = sram_rdata_r;
    assign rdata_g      = sram_rdata_g;
    assign rdata_b      = sram_rdata_b;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: stimulus queues expected events, a negedge monitor checks them.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req, we, lock;
    logic [41:0] addr;
    logic [95:0] wdata_r, wdata_g, wdata_b;
    logic [2:0]  gnt, rvalid;
    logic [31:0] rdata_r, rdata_g, rdata_b;
    logic        sram_wr_en, sram_rd_en;
    logic [13:0] sram_addr;
    logic [31:0] sram_wdata_r, sram_wdata_g, sram_wdata_b;
    logic [31:0] sram_rdata_r, sram_rdata_g, sram_rdata_b;
    logic        arb_busy, lock_timeout;

    sram_port_arbiter #(
        .N_REQ(3), .ADDR_W(14), .DATA_W(32), .RD_LAT(2), .LOCK_TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock), .addr(addr),
        .wdata_r(wdata_r), .wdata_g(wdata_g), .wdata_b(wdata_b),
        .gnt(gnt), .rvalid(rvalid),
        .rdata_r(rdata_r), .rdata_g(rdata_g), .rdata_b(rdata_b),
        .sram_wr_en(sram_wr_en), .sram_rd_en(sram_rd_en), .sram_addr(sram_addr),
        .sram_wdata_r(sram_wdata_r), .sram_wdata_g(sram_wdata_g), .sram_wdata_b(sram_wdata_b),
        .sram_rdata_r(sram_rdata_r), .sram_rdata_g(sram_rdata_g), .sram_rdata_b(sram_rdata_b),
        .arb_busy(arb_busy), .lock_timeout(lock_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model with 2-cycle read latency; the word encodes its address per lane.
    logic [13:0] a1, a2;
    always @(posedge clk) begin
        a1 <= sram_addr;
        a2 <= a1;
    end
    assign sram_rdata_r = {8'hA1, 10'd0, a2};
    assign sram_rdata_g = {8'hB2, 10'd0, a2};
    assign sram_rdata_b = {8'hC3, 10'd0, a2};

    int n_tests = 0;
    int n_fail  = 0;

    logic [159:0] q_gnt[$], q_acc[$], q_rv[$], q_lto[$], q_busy[$];

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic unexp(input string nm, input logic [159:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %h want none", nm, act);
    endtask

    function automatic void exp_gnt(input int s, input int len, input logic [2:0] g);
        q_gnt.push_back(160'({s, len, 29'd0, g}));
    endfunction

    function automatic void exp_acc(input int c, input logic wr, input logic [13:0] a,
                                    input logic [31:0] r, input logic [31:0] g, input logic [31:0] b);
        q_acc.push_back(160'({c, wr, ~wr, a, r, g, b}));
    endfunction

    function automatic void exp_rv(input int c, input logic [13:0] a);
        q_rv.push_back(160'({c, 3'b100, 8'hA1, 10'd0, a, 8'hB2, 10'd0, a, 8'hC3, 10'd0, a}));
    endfunction

    function automatic void exp_busy(input int s, input int len);
        q_busy.push_back(160'({s, len}));
    endfunction

    // Monitor: grant and busy are reported as {start, length} when they fall.
    logic [2:0] gp = 3'b000;
    int         gs = 0;
    logic       bp = 1'b0;
    int         bs = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (gnt !== gp) begin
                if (gp != 3'b000) begin
                    if (q_gnt.size() == 0) unexp("gnt", 160'({gs, cyc - gs, 29'd0, gp}));
                    else chk("gnt", 160'({gs, cyc - gs, 29'd0, gp}), q_gnt.pop_front());
                end
                if (gnt != 3'b000) gs = cyc;
                gp = gnt;
            end
            if (sram_wr_en === 1'b1 || sram_rd_en === 1'b1) begin
                if (q_acc.size() == 0)
                    unexp("access", 160'({cyc, sram_wr_en, sram_rd_en, sram_addr, sram_wdata_r, sram_wdata_g, sram_wdata_b}));
                else
                    chk("access", 160'({cyc, sram_wr_en, sram_rd_en, sram_addr, sram_wdata_r, sram_wdata_g, sram_wdata_b}),
                        q_acc.pop_front());
            end
            if (rvalid !== 3'b000) begin
                if (q_rv.size() == 0) unexp("rvalid", 160'({cyc, rvalid, rdata_r, rdata_g, rdata_b}));
                else chk("rvalid", 160'({cyc, rvalid, rdata_r, rdata_g, rdata_b}), q_rv.pop_front());
            end
            if (lock_timeout === 1'b1) begin
                if (q_lto.size() == 0) unexp("lock_timeout", 160'(cyc));
                else chk("lock_timeout", 160'(cyc), q_lto.pop_front());
            end
            if (arb_busy !== bp) begin
                if (bp) begin
                    if (q_busy.size() == 0) unexp("busy", 160'({bs, cyc - bs}));
                    else chk("busy", 160'({bs, cyc - bs}), q_busy.pop_front());
                end else begin
                    bs = cyc;
                end
                bp = arb_busy;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic r, input logic w, input logic l, input logic [13:0] a,
                           input logic [31:0] dr, input logic [31:0] dg, input logic [31:0] db);
        req[i]  = r;
        we[i]   = w;
        lock[i] = l;
        addr[i*14 +: 14]    = a;
        wdata_r[i*32 +: 32] = dr;
        wdata_g[i*32 +: 32] = dg;
        wdata_b[i*32 +: 32] = db;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0; we = '0; lock = '0; addr = '0;
        wdata_r = '0; wdata_g = '0; wdata_b = '0;
        tick();
        tick();
        chk("reset_outputs",
            160'({gnt, rvalid, sram_wr_en, sram_rd_en, arb_busy, lock_timeout, sram_addr, sram_wdata_r}), 160'(0));
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        do_reset();

        // 1: lone unlocked write from requester 1
        c = cyc;
        set_req(1, 1'b1, 1'b1, 1'b0, 14'h0005, 32'h11, 32'h22, 32'h33);
        exp_gnt(c + 1, 1, 3'b010);
        exp_acc(c + 1, 1'b1, 14'h0005, 32'h11, 32'h22, 32'h33);
        exp_busy(c + 1, 2);
        tick(); tick();
        req[1] = 1'b0;
        tick(); tick();

        // 2: simultaneous unlocked requests from reset -> 0, 1, 2 spaced 3 cycles
        do_reset();
        c = cyc;
        set_req(0, 1'b1, 1'b1, 1'b0, 14'h0100, 32'hA0, 32'hA1, 32'hA2);
        set_req(1, 1'b1, 1'b1, 1'b0, 14'h0101, 32'hB0, 32'hB1, 32'hB2);
        set_req(2, 1'b1, 1'b1, 1'b0, 14'h0102, 32'hC0, 32'hC1, 32'hC2);
        exp_gnt(c + 1, 1, 3'b001); exp_acc(c + 1, 1'b1, 14'h0100, 32'hA0, 32'hA1, 32'hA2); exp_busy(c + 1, 2);
        exp_gnt(c + 4, 1, 3'b010); exp_acc(c + 4, 1'b1, 14'h0101, 32'hB0, 32'hB1, 32'hB2); exp_busy(c + 4, 2);
        exp_gnt(c + 7, 1, 3'b100); exp_acc(c + 7, 1'b1, 14'h0102, 32'hC0, 32'hC1, 32'hC2); exp_busy(c + 7, 2);
        for (int k = 1; k <= 10; k++) begin
            tick();
            for (int i = 0; i < 3; i++) if (cyc == c + 2 + 3 * i) req[i] = 1'b0;
        end

        // 4: locked reads from requester 2, 2-cycle return
        c = cyc;
        set_req(2, 1'b1, 1'b0, 1'b1, 14'd10, 32'h0, 32'h0, 32'h0);
        exp_gnt(c + 1, 4, 3'b100);
        exp_busy(c + 1, 5);
        for (int k = 0; k < 3; k++) begin
            exp_acc(c + 1 + k, 1'b0, 14'(10 + k), 32'h0, 32'h0, 32'h0);
            exp_rv(c + 3 + k, 14'(10 + k));
        end
        tick();
        tick(); addr[28 +: 14] = 14'd11;
        tick(); addr[28 +: 14] = 14'd12;
        tick(); req[2] = 1'b0; lock[2] = 1'b0;
        tick(); tick(); tick(); tick();

        // 5: idle locked owner times out after 8 cycles; pending requester 1 served next
        c = cyc;
        set_req(0, 1'b1, 1'b1, 1'b1, 14'h0040, 32'h1, 32'h2, 32'h3);
        exp_gnt(c + 1, 8, 3'b001);
        exp_busy(c + 1, 9);
        q_lto.push_back(160'(c + 9));
        exp_gnt(c + 11, 1, 3'b010);
        exp_acc(c + 11, 1'b1, 14'h0041, 32'h5, 32'h6, 32'h7);
        exp_busy(c + 11, 2);
        tick();
        req[0] = 1'b0;
        set_req(1, 1'b1, 1'b1, 1'b0, 14'h0041, 32'h5, 32'h6, 32'h7);
        while (cyc < c + 14) begin
            tick();
            if (cyc == c + 9)  lock[0] = 1'b0;
            if (cyc == c + 12) req[1] = 1'b0;
        end

        // 3: locked 16K-write burst from requester 0 while requester 2 waits
        c = cyc;
        set_req(0, 1'b1, 1'b1, 1'b1, 14'd0, 32'd0, 32'd0, ~32'd0);
        exp_gnt(c + 1, 16384, 3'b001);
        exp_busy(c + 1, 16385);
        for (int i = 0; i < 16384; i++)
            exp_acc(c + 1 + i, 1'b1, 14'(i), 32'(i), 32'(i) << 4, ~32'(i));
        exp_gnt(c + 16387, 1, 3'b100);
        exp_acc(c + 16387, 1'b0, 14'd7, 32'h0, 32'h0, 32'h0);
        exp_busy(c + 16387, 2);
        exp_rv(c + 16389, 14'd7);
        tick();
        set_req(2, 1'b1, 1'b0, 1'b0, 14'd7, 32'h0, 32'h0, 32'h0);
        for (int i = 1; i < 16384; i++) begin
            tick();
            set_req(0, 1'b1, 1'b1, (i != 16383), 14'(i), 32'(i), 32'(i) << 4, ~32'(i));
        end
        tick(); req[0] = 1'b0;
        while (cyc < c + 16392) begin
            tick();
            if (cyc == c + 16388) req[2] = 1'b0;
        end

        // 6: reset mid-burst with reads in flight, then requester 0 wins first
        do_reset();
        c = cyc;
        set_req(2, 1'b1, 1'b0, 1'b1, 14'd20, 32'h0, 32'h0, 32'h0);
        exp_gnt(c + 1, 2, 3'b100);
        exp_busy(c + 1, 2);
        exp_acc(c + 1, 1'b0, 14'd20, 32'h0, 32'h0, 32'h0);
        exp_acc(c + 2, 1'b0, 14'd21, 32'h0, 32'h0, 32'h0);
        tick();
        tick(); addr[28 +: 14] = 14'd21; rst = 1'b1;
        tick();
        chk("rst_mid_burst", 160'({gnt, sram_wr_en, sram_rd_en, rvalid}), 160'(0));
        req[2] = 1'b0; lock[2] = 1'b0;
        tick();
        chk("rst_drop_rvalid", 160'({gnt, rvalid, arb_busy}), 160'(0));
        rst = 1'b0;
        c = cyc;
        set_req(0, 1'b1, 1'b1, 1'b0, 14'h002A, 32'hD0, 32'hD1, 32'hD2);
        set_req(2, 1'b1, 1'b0, 1'b0, 14'd30, 32'h0, 32'h0, 32'h0);
        exp_gnt(c + 1, 1, 3'b001); exp_acc(c + 1, 1'b1, 14'h002A, 32'hD0, 32'hD1, 32'hD2); exp_busy(c + 1, 2);
        exp_gnt(c + 4, 1, 3'b100); exp_acc(c + 4, 1'b0, 14'd30, 32'h0, 32'h0, 32'h0); exp_busy(c + 4, 2);
        exp_rv(c + 6, 14'd30);
        while (cyc < c + 10) begin
            tick();
            if (cyc == c + 2) req[0] = 1'b0;
            if (cyc == c + 5) req[2] = 1'b0;
        end

        chk("left_gnt",  160'(q_gnt.size()),  160'(0));
        chk("left_acc",  160'(q_acc.size()),  160'(0));
        chk("left_rv",   160'(q_rv.size()),   160'(0));
        chk("left_lto",  160'(q_lto.size()),  160'(0));
        chk("left_busy", 160'(q_busy.size()), 160'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
